// File: rtl/ahblite_interconnect_param.sv
// Single-master AHB-Lite interconnect: address decode, registered data-phase response mux,
// built-in default slave that answers unmapped transfers, and fault capture for software.
module ahblite_interconnect_param #(
  parameter int                         NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*32-1:0]   ADDR_BASE   = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*32-1:0]   ADDR_MASK   = {NUM_SLAVES{32'hF000_0000}},
  parameter bit                         DEFAULT_ERR = 1'b1
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [2:0]                 HBURST,
  input  logic [3:0]                 HPROT,
  input  logic                       HMASTLOCK,
  input  logic [31:0]                HWDATA,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic [31:0]                HRDATA,
  output logic [31:0]                HADDR_S,
  output logic [1:0]                 HTRANS_S,
  output logic                       HWRITE_S,
  output logic [2:0]                 HSIZE_S,
  output logic [2:0]                 HBURST_S,
  output logic [3:0]                 HPROT_S,
  output logic                       HMASTLOCK_S,
  output logic [31:0]                HWDATA_S,
  output logic                       HREADY_S,
  output logic [NUM_SLAVES-1:0]      HSEL_S,
  input  logic [NUM_SLAVES-1:0]      HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]      HRESP_S,
  input  logic [NUM_SLAVES*32-1:0]   HRDATA_S,
  output logic [31:0]                ERR_ADDR,
  output logic [7:0]                 ERR_CNT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [NUM_SLAVES-1:0] hsel;
  logic                  hit;
  logic                  miss;
  logic [NUM_SLAVES-1:0] sel_d, sel_q;
  logic                  dflt_d, dflt_q;
  logic [1:0]            state_d, state_q;
  logic [31:0]           err_addr_d, err_addr_q;
  logic [7:0]            err_cnt_d, err_cnt_q;
  logic                  hready;
  logic                  hresp;
  logic [31:0]           hrdata;

  // Lowest-index window wins when windows overlap.
  always_comb begin
    hsel = '0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32])) begin
        hsel[i] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  assign miss = ~hit;

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    if (state_q == ST_ERR1) begin
      hready = 1'b0;
      hresp  = 1'b1;
    end else if (state_q == ST_ERR2) begin
      hready = 1'b1;
      hresp  = 1'b1;
    end else if (!dflt_q) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_q[i]) begin
          hready = HREADYOUT_S[i];
          hresp  = HRESP_S[i];
          hrdata = HRDATA_S[32*i +: 32];
        end
      end
    end
  end

  // Address phase is only accepted while HREADY is high; otherwise everything holds.
  always_comb begin
    sel_d      = hready ? hsel : sel_q;
    dflt_d     = hready ? miss : dflt_q;
    state_d    = state_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (DEFAULT_ERR && hready && HTRANS[1] && miss) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        state_d = (HTRANS[1] && miss) ? ST_ERR1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ERR1) begin
      err_addr_d = HADDR;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q      <= '0;
      dflt_q     <= 1'b0;
      state_q    <= ST_IDLE;
      err_addr_q <= 32'h0;
      err_cnt_q  <= 8'h0;
    end else begin
      sel_q      <= sel_d;
      dflt_q     <= dflt_d;
      state_q    <= state_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign HREADY      = hready;
  assign HRESP       = hresp;
  assign HRDATA      = hrdata;
  assign HADDR_S     = HADDR;
  assign HTRANS_S    = HTRANS;
  assign HWRITE_S    = HWRITE;
  assign HSIZE_S     = HSIZE;
  assign HBURST_S    = HBURST;
  assign HPROT_S     = HPROT;
  assign HMASTLOCK_S = HMASTLOCK;
  assign HWDATA_S    = HWDATA;
  assign HREADY_S    = hready;
  assign HSEL_S      = hsel;
  assign ERR_ADDR    = err_addr_q;
  assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_ahblite_interconnect_param.sv
// Bench for ahblite_interconnect_param: a two-slave erroring build (A) with modelled slaves,
// and a non-erroring build (B) with overlapping windows sharing the same master signals.
module tb_ahblite_interconnect_param;

  logic        hClk;
  logic        hResetN;
  logic [31:0] hAddr;
  logic [1:0]  hTrans;
  logic        hWrite;
  logic [2:0]  hSize;
  logic [2:0]  hBurst;
  logic [3:0]  hProt;
  logic        hMastlock;
  logic [31:0] hWdata;
  logic        tagValid;

  // Build A outputs and slave-side inputs
  logic        hReadyA, hRespA;
  logic [31:0] hRdataA, hAddrSA, hWdataSA, errAddrA;
  logic [1:0]  hTransSA;
  logic        hWriteSA, hMastlockSA, hReadySA;
  logic [2:0]  hSizeSA, hBurstSA;
  logic [3:0]  hProtSA;
  logic [1:0]  hSelA;
  logic [7:0]  errCntA;
  logic [1:0]  hReadyOutA;
  logic [63:0] hRdataSA;
  wire  [1:0]  hRespSlvA = 2'b00;

  // Build B outputs
  logic        hReadyB, hRespB;
  logic [31:0] hRdataB, hAddrSB, hWdataSB, errAddrB;
  logic [1:0]  hTransSB;
  logic        hWriteSB, hMastlockSB, hReadySB;
  logic [2:0]  hSizeSB, hBurstSB;
  logic [3:0]  hProtSB;
  logic [1:0]  hSelB;
  logic [7:0]  errCntB;
  wire  [1:0]  hReadyOutB = 2'b11;
  wire  [1:0]  hRespSlvB  = 2'b00;
  wire  [63:0] hRdataSB   = {32'hBBBB_BBBB, 32'hAAAA_AAAA};

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    int          waits;
    logic        resp;
    logic [31:0] rdata;
    bit          chkRdata;
  } exp_t;
  exp_t sbQ[$];

  int          sWait[2]  = '{0, 2};
  logic [31:0] sRdata[2] = '{32'h1111_0000, 32'hCAFE_F00D};
  bit          sActive[2];
  int          sCnt[2];

  ahblite_interconnect_param #(
    .NUM_SLAVES(2),
    .ADDR_BASE({32'h2000_0000, 32'h0000_0000}),
    .ADDR_MASK({32'hF000_0000, 32'hF000_0000}),
    .DEFAULT_ERR(1'b1)
  ) dutA (
    .HCLK(hClk), .HRESETn(hResetN),
    .HADDR(hAddr), .HTRANS(hTrans), .HWRITE(hWrite), .HSIZE(hSize), .HBURST(hBurst),
    .HPROT(hProt), .HMASTLOCK(hMastlock), .HWDATA(hWdata),
    .HREADY(hReadyA), .HRESP(hRespA), .HRDATA(hRdataA),
    .HADDR_S(hAddrSA), .HTRANS_S(hTransSA), .HWRITE_S(hWriteSA), .HSIZE_S(hSizeSA),
    .HBURST_S(hBurstSA), .HPROT_S(hProtSA), .HMASTLOCK_S(hMastlockSA), .HWDATA_S(hWdataSA),
    .HREADY_S(hReadySA), .HSEL_S(hSelA),
    .HREADYOUT_S(hReadyOutA), .HRESP_S(hRespSlvA), .HRDATA_S(hRdataSA),
    .ERR_ADDR(errAddrA), .ERR_CNT(errCntA)
  );

  ahblite_interconnect_param #(
    .NUM_SLAVES(2),
    .ADDR_BASE({32'h4000_0000, 32'h4000_0000}),
    .ADDR_MASK({32'hFF00_0000, 32'hF000_0000}),
    .DEFAULT_ERR(1'b0)
  ) dutB (
    .HCLK(hClk), .HRESETn(hResetN),
    .HADDR(hAddr), .HTRANS(hTrans), .HWRITE(hWrite), .HSIZE(hSize), .HBURST(hBurst),
    .HPROT(hProt), .HMASTLOCK(hMastlock), .HWDATA(hWdata),
    .HREADY(hReadyB), .HRESP(hRespB), .HRDATA(hRdataB),
    .HADDR_S(hAddrSB), .HTRANS_S(hTransSB), .HWRITE_S(hWriteSB), .HSIZE_S(hSizeSB),
    .HBURST_S(hBurstSB), .HPROT_S(hProtSB), .HMASTLOCK_S(hMastlockSB), .HWDATA_S(hWdataSB),
    .HREADY_S(hReadySB), .HSEL_S(hSelB),
    .HREADYOUT_S(hReadyOutB), .HRESP_S(hRespSlvB), .HRDATA_S(hRdataSB),
    .ERR_ADDR(errAddrB), .ERR_CNT(errCntB)
  );

  initial hClk = 1'b0;
  always #5 hClk = ~hClk;

  // Slave models for build A: sample the address phase at the edge, drive responses 1ns later.
  always @(posedge hClk or negedge hResetN) begin
    if (!hResetN) begin
      for (int i = 0; i < 2; i++) begin
        sActive[i] = 1'b0;
        sCnt[i]    = 0;
      end
      hReadyOutA = 2'b11;
      hRdataSA   = 64'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (hReadyA) begin
          if (hSelA[i] && hTransSA[1]) begin
            sActive[i] = 1'b1;
            sCnt[i]    = sWait[i];
          end else begin
            sActive[i] = 1'b0;
          end
        end else if (sActive[i] && sCnt[i] > 0) begin
          sCnt[i] = sCnt[i] - 1;
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        hReadyOutA[i]         = !(sActive[i] && sCnt[i] != 0);
        hRdataSA[32*i +: 32]  = sActive[i] ? sRdata[i] : 32'h0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: follows tagged data phases of build A and scores each one when HREADY completes it.
  bit          dpActive = 1'b0;
  bit          dpFirst;
  int          dpWaits;
  logic        dpRespFirst;
  always @(negedge hClk) begin
    exp_t e;
    if (!hResetN) begin
      dpActive = 1'b0;
    end else begin
      if (dpActive) begin
        if (dpFirst) begin
          dpRespFirst = hRespA;
          dpFirst     = 1'b0;
        end
        if (!hReadyA) begin
          dpWaits++;
        end else begin
          if (sbQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL sb_unexpected: transfer completed with no expectation queued");
          end else begin
            e = sbQ.pop_front();
            checkOutput({e.name, "_waits"}, 32'(dpWaits), 32'(e.waits));
            checkOutput({e.name, "_resp_first"}, 32'(dpRespFirst), 32'(e.resp));
            checkOutput({e.name, "_resp_last"}, 32'(hRespA), 32'(e.resp));
            if (e.chkRdata) checkOutput({e.name, "_rdata"}, hRdataA, e.rdata);
          end
          dpActive = 1'b0;
        end
      end
      if (hReadyA && tagValid) begin
        dpActive = 1'b1;
        dpFirst  = 1'b1;
        dpWaits  = 0;
      end
    end
  end

  task automatic idleBus();
    hAddr    = 32'h0;
    hTrans   = 2'b00;
    tagValid = 1'b0;
  endtask

  task automatic finishBus();
    @(posedge hClk); #2;
    idleBus();
  endtask

  // Drives one address phase and returns on the negedge where build A accepts it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans, input bit tag,
                               input logic [1:0] expSel, input string name, input int expWaits,
                               input logic expResp, input logic [31:0] expRdata, input bit chkRdata);
    exp_t e;
    bit   accepted;
    @(posedge hClk); #2;
    hAddr    = addr;
    hTrans   = trans;
    tagValid = tag;
    if (tag) begin
      e.name = name; e.waits = expWaits; e.resp = expResp; e.rdata = expRdata; e.chkRdata = chkRdata;
      sbQ.push_back(e);
    end
    #1;
    checkOutput({name, "_hsel"}, 32'(hSelA), 32'(expSel));
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge hClk);
      if (hReadyA) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s_accept: HREADY stayed 0, expected 1 within 20 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hResetN   = 1'b0;
    hWrite    = 1'b0;
    hSize     = 3'b010;
    hBurst    = 3'b000;
    hProt     = 4'b0011;
    hMastlock = 1'b0;
    hWdata    = 32'h1234_5678;
    idleBus();
    repeat (2) @(posedge hClk);
    #2;
    checkOutput("reset_hready", 32'(hReadyA), 32'd1);
    checkOutput("reset_hresp", 32'(hRespA), 32'd0);
    checkOutput("reset_hrdata", hRdataA, 32'h0);
    checkOutput("reset_err_cnt", 32'(errCntA), 32'd0);
    checkOutput("reset_err_addr", errAddrA, 32'h0);
    hResetN = 1'b1;

    applyStimulus(32'h2000_0010, 2'b10, 1'b1, 2'b10, "s1_read_wait", 2, 1'b0, 32'hCAFE_F00D, 1'b1);
    applyStimulus(32'h0000_0040, 2'b10, 1'b1, 2'b01, "s0_read", 0, 1'b0, 32'h1111_0000, 1'b1);
    applyStimulus(32'h9000_0004, 2'b10, 1'b1, 2'b00, "unmapped_err", 1, 1'b1, 32'h0, 1'b0);
    @(posedge hClk); #2;
    idleBus();
    checkOutput("err1_hready", 32'(hReadyA), 32'd0);
    checkOutput("err1_hresp", 32'(hRespA), 32'd1);
    checkOutput("b_unmapped_hready", 32'(hReadyB), 32'd1);
    checkOutput("b_unmapped_hresp", 32'(hRespB), 32'd0);
    checkOutput("b_unmapped_hrdata", hRdataB, 32'h0);
    repeat (3) @(posedge hClk);
    @(negedge hClk);
    checkOutput("err_addr_first", errAddrA, 32'h9000_0004);
    checkOutput("err_cnt_first", 32'(errCntA), 32'd1);

    applyStimulus(32'hA000_0000, 2'b10, 1'b1, 2'b00, "b2b_err_a", 1, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'hB000_0008, 2'b11, 1'b1, 2'b00, "b2b_err_b", 1, 1'b1, 32'h0, 1'b0);
    finishBus();
    repeat (4) @(posedge hClk);
    @(negedge hClk);
    checkOutput("err_cnt_b2b", 32'(errCntA), 32'd3);
    checkOutput("err_addr_b2b", errAddrA, 32'hB000_0008);

    applyStimulus(32'hC000_0000, 2'b00, 1'b1, 2'b00, "idle_unmapped", 0, 1'b0, 32'h0, 1'b1);
    finishBus();
    repeat (3) @(posedge hClk);
    @(negedge hClk);
    checkOutput("err_cnt_after_idle", 32'(errCntA), 32'd3);

    @(posedge hClk); #2;
    hAddr = 32'h4000_1000;
    #1;
    checkOutput("b_overlap_hsel", 32'(hSelB), 32'h1);
    checkOutput("a_overlap_hsel", 32'(hSelA), 32'h0);
    checkOutput("broadcast_hwdata", hWdataSA, 32'h1234_5678);
    idleBus();

    // Reset asserted in the middle of an ERR1 cycle.
    applyStimulus(32'hD000_0000, 2'b10, 1'b0, 2'b00, "rst_err", 0, 1'b0, 32'h0, 1'b0);
    @(posedge hClk); #2;
    idleBus();
    checkOutput("rst_err_pre_hready", 32'(hReadyA), 32'd0);
    checkOutput("rst_err_pre_addr", errAddrA, 32'hD000_0000);
    hResetN = 1'b0;
    #1;
    checkOutput("rst_err_hready", 32'(hReadyA), 32'd1);
    checkOutput("rst_err_hresp", 32'(hRespA), 32'd0);
    checkOutput("rst_err_cnt", 32'(errCntA), 32'd0);
    checkOutput("rst_err_addr", errAddrA, 32'h0);
    @(posedge hClk); #2;
    hResetN = 1'b1;

    // Reset asserted while slave 1 is inserting wait states.
    applyStimulus(32'h2000_0020, 2'b10, 1'b0, 2'b10, "rst_wait", 0, 1'b0, 32'h0, 1'b0);
    @(posedge hClk); #2;
    idleBus();
    checkOutput("rst_wait_pre_hready", 32'(hReadyA), 32'd0);
    hResetN = 1'b0;
    #1;
    checkOutput("rst_wait_hready", 32'(hReadyA), 32'd1);
    checkOutput("rst_wait_hresp", 32'(hRespA), 32'd0);
    checkOutput("rst_wait_hrdata", hRdataA, 32'h0);
    @(posedge hClk); #2;
    hResetN = 1'b1;

    for (int n = 0; n < 260; n++) begin
      applyStimulus(32'hE000_0000 | (32'(n) << 2), 2'b10, 1'b0, 2'b00, "sat", 0, 1'b0, 32'h0, 1'b0);
    end
    finishBus();
    repeat (4) @(posedge hClk);
    @(negedge hClk);
    checkOutput("err_cnt_saturated", 32'(errCntA), 32'd255);
    checkOutput("err_addr_last", errAddrA, 32'hE000_040C);
    checkOutput("b_err_cnt", 32'(errCntB), 32'd0);

    repeat (3) @(negedge hClk);
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
